// File: rtl/mux_2to1_if.sv
// Bus bundle for mux_2to1: data/select inputs plus combinational, registered and switch-tracking outputs.
interface mux_2to1_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic             sel;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] mux_out_q;
  logic             sel_q;
  logic             switch_pulse;
  logic [CNT_W-1:0] switch_cnt;

  modport master (
    output en, sel, in_1, in_2,
    input  mux_out, mux_out_q, sel_q, switch_pulse, switch_cnt
  );

  modport slave (
    input  en, sel, in_1, in_2,
    output mux_out, mux_out_q, sel_q, switch_pulse, switch_cnt
  );
endinterface

// File: rtl/mux_2to1.sv
// 2:1 mux with combinational and registered outputs plus select-change tracking.
// Switch pulse/counter exist only when MUX_2TO1_SWITCH_CNT_EN is defined; otherwise tied to 0.
module mux_2to1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_2to1_if.slave bus
);
  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] q_r;
  logic             sel_r;

  assign mux_d         = bus.sel ? bus.in_2 : bus.in_1;
  assign bus.mux_out   = mux_d;
  assign bus.mux_out_q = q_r;
  assign bus.sel_q     = sel_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '0;
      sel_r <= 1'b0;
    end else begin
      if (bus.en) q_r <= mux_d;
      sel_r <= bus.sel;
    end
  end

`ifdef MUX_2TO1_SWITCH_CNT_EN
  logic             pulse_r;
  logic [CNT_W-1:0] cnt_r;

  // if-form keeps an unknown sel from poisoning the pulse/count: X compares as no switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      if (bus.sel != sel_r) begin
        pulse_r <= 1'b1;
        if (cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        pulse_r <= 1'b0;
      end
    end
  end

  assign bus.switch_pulse = pulse_r;
  assign bus.switch_cnt   = cnt_r;
`else
  assign bus.switch_pulse = 1'b0;
  assign bus.switch_cnt   = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: two instances (8-bit counter and 2-bit saturating counter) share stimulus.
`timescale 1ns/1ps
module tb_mux_2to1;
  localparam int W = 8;
`ifdef MUX_2TO1_SWITCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clk_run = 1'b0;
  logic         rst_n;
  logic         en, sel;
  logic [W-1:0] in_1, in_2;

  always #5 if (clk_run) clk = ~clk;

  mux_2to1_if #(.WIDTH(W), .CNT_W(8)) bus_a ();
  mux_2to1_if #(.WIDTH(W), .CNT_W(2)) bus_b ();

  assign bus_a.en = en;  assign bus_a.sel = sel;  assign bus_a.in_1 = in_1;  assign bus_a.in_2 = in_2;
  assign bus_b.en = en;  assign bus_b.sel = sel;  assign bus_b.in_1 = in_1;  assign bus_b.in_2 = in_2;

  mux_2to1 #(.WIDTH(W), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_2to1 #(.WIDTH(W), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference state as of the most recent modelled edge
  logic [W-1:0] m_q;
  logic         m_selq, m_pulse;
  int           m_cnt_a, m_cnt_b;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow: got %0h want <nothing queued>", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_selq = 1'b0; m_pulse = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // Predict the next edge from current inputs, queue expectations, clock once, compare.
  task automatic step();
    if (en) m_q = sel ? in_2 : in_1;
    m_pulse = (sel != m_selq);
    if (m_pulse) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3)   m_cnt_b++;
    end
    m_selq = sel;
    push("q_a",     32'(m_q));
    push("sel_q_a", 32'(m_selq));
    push("pulse_a", CNT_ON ? 32'(m_pulse) : 32'd0);
    push("cnt_a",   CNT_ON ? 32'(m_cnt_a) : 32'd0);
    push("q_b",     32'(m_q));
    push("pulse_b", CNT_ON ? 32'(m_pulse) : 32'd0);
    push("cnt_b",   CNT_ON ? 32'(m_cnt_b) : 32'd0);
    @(posedge clk);
    #1;
    pop_chk(32'(bus_a.mux_out_q));
    pop_chk(32'(bus_a.sel_q));
    pop_chk(32'(bus_a.switch_pulse));
    pop_chk(32'(bus_a.switch_cnt));
    pop_chk(32'(bus_b.mux_out_q));
    pop_chk(32'(bus_b.switch_pulse));
    pop_chk(32'(bus_b.switch_cnt));
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_q_a"},     32'(bus_a.mux_out_q),    32'd0);
    chk({tag, "_sel_q_a"}, 32'(bus_a.sel_q),        32'd0);
    chk({tag, "_pulse_a"}, 32'(bus_a.switch_pulse), 32'd0);
    chk({tag, "_cnt_a"},   32'(bus_a.switch_cnt),   32'd0);
    chk({tag, "_q_b"},     32'(bus_b.mux_out_q),    32'd0);
    chk({tag, "_cnt_b"},   32'(bus_b.switch_cnt),   32'd0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; en = 1'b0; sel = 1'b1; in_1 = 8'h01; in_2 = 8'h00;

    // combinational path with no clock running
    #5 chk("comb_sel1", 32'(bus_a.mux_out), 32'h00);
    sel = 1'b0;
    #5 chk("comb_sel0", 32'(bus_a.mux_out), 32'h01);
    chk_reset("rst_init");

    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // registered path
    in_1 = 8'hA5; in_2 = 8'h3C; en = 1'b1; sel = 1'b0;
    step();
    sel = 1'b1;
    step();

    // enable hold: q frozen, mux_out and sel_q still track
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel  = 1'($urandom_range(0, 1));
      in_1 = 8'($urandom);
      in_2 = 8'($urandom);
      #1 chk("comb_hold", 32'(bus_a.mux_out), 32'(sel ? in_2 : in_1));
      step();
    end

    // bring count to 5 with q at 0x3C, then reset between edges
    en = 1'b1; in_1 = 8'h3C; in_2 = 8'h3C;
    for (int i = 0; i < 12 && m_cnt_a < 5; i++) begin
      sel = ~sel;
      step();
    end
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // sel=1 on the first edge after release counts as a switch
    sel = 1'b1; in_1 = 8'h5A; in_2 = 8'hC3;
    step();

    // toggle every cycle: pulse every cycle, 2-bit counter saturates at 3
    for (int i = 0; i < 6; i++) begin
      sel  = ~sel;
      in_1 = 8'($urandom);
      in_2 = 8'($urandom);
      step();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
